// File: rtl/event_frontend_pkg.sv
// Shared types and helpers for the DVS event ingress front end.
package event_frontend_pkg;

    // Field widths are upper bounds; the front end zero-extends into them.
    localparam int unsigned EVT_X_W = 16;
    localparam int unsigned EVT_Y_W = 16;
    localparam int unsigned EVT_T_W = 64;

    typedef struct packed {
        logic [EVT_X_W-1:0] x;
        logic [EVT_Y_W-1:0] y;
        logic [EVT_T_W-1:0] t;
        logic               pol;
        logic               sow;
    } evt_t;

    typedef enum logic {
        WIN_IDLE,
        WIN_ACTIVE
    } win_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned bits);
        logic [31:0] max_val;
        max_val = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/event_input_frontend_fifo.sv
// First-word-fall-through FIFO: storage array plus a registered head entry.
module event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             head_valid;
    logic             pop;
    logic             load;

    // The head register refills from storage whenever it is free or being consumed.
    assign pop   = head_valid && rd_en;
    assign load  = (mem_cnt != '0) && (!head_valid || pop);
    assign level = mem_cnt + {{AW{1'b0}}, head_valid};
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = !head_valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            head_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr     <= rd_ptr + AW'(1);
                rd_data    <= mem[rd_ptr];
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + (AW+1)'(wr_en) - (AW+1)'(load);
        end
    end

endmodule

// File: rtl/event_input_frontend.sv
// Event ingress: bounds check, scaling, window tagging and FWFT buffering.
// Optional EVT_MONOTONIC_CHECK_EN drops events whose timestamp precedes the window start.
module event_input_frontend
    import event_frontend_pkg::*;
#(
    parameter int unsigned MAX_X_COORD    = 128,
    parameter int unsigned MAX_Y_COORD    = 128,
    parameter int unsigned INPUT_BIT_TIME = 32,
    parameter int unsigned INPUT_BIT_X    = 8,
    parameter int unsigned INPUT_BIT_Y    = 8,
    parameter int unsigned SCALE_SHIFT    = 0,
    parameter int unsigned WINDOW_LEN     = 100000,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [INPUT_BIT_TIME-1:0]       timestamp,
    input  logic [INPUT_BIT_X-1:0]          x_coord,
    input  logic [INPUT_BIT_Y-1:0]          y_coord,
    input  logic                            polarity,
    input  logic                            is_valid,
    output logic [INPUT_BIT_X-1:0]          out_x,
    output logic [INPUT_BIT_Y-1:0]          out_y,
    output logic [INPUT_BIT_TIME-1:0]       out_t,
    output logic                            out_pol,
    output logic                            out_sow,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [CNT_BITS-1:0]             oob_drops,
    output logic [CNT_BITS-1:0]             ovf_drops,
    output logic [CNT_BITS-1:0]             ooo_drops
);
    localparam int unsigned DATA_W = INPUT_BIT_X + INPUT_BIT_Y + INPUT_BIT_TIME + 2;

    win_state_e                state;
    logic [INPUT_BIT_TIME-1:0] window_start;
    logic [INPUT_BIT_TIME-1:0] delta;
    logic [INPUT_BIT_X-1:0]    x_scaled;
    logic [INPUT_BIT_Y-1:0]    y_scaled;
    logic                      in_bounds;
    logic                      new_window;
    evt_t                      s1_evt;
    logic                      s1_valid;
    logic                      pending_sow;
    logic                      fifo_wr;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DATA_W-1:0]         fifo_din;
    logic [DATA_W-1:0]         fifo_dout;
    logic                      unused_evt_bits;

    assign in_bounds  = (32'(x_coord) < MAX_X_COORD) && (32'(y_coord) < MAX_Y_COORD);
    assign delta      = timestamp - window_start;
    assign new_window = (state == WIN_IDLE) || (delta >= INPUT_BIT_TIME'(WINDOW_LEN));
    assign x_scaled   = x_coord >> SCALE_SHIFT;
    assign y_scaled   = y_coord >> SCALE_SHIFT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= WIN_IDLE;
            window_start <= '0;
            s1_valid     <= 1'b0;
            s1_evt       <= '0;
            oob_drops    <= '0;
`ifdef EVT_MONOTONIC_CHECK_EN
            ooo_drops    <= '0;
`endif
        end else begin
            s1_valid <= 1'b0;
            if (is_valid) begin
                if (!in_bounds) begin
                    oob_drops <= CNT_BITS'(sat_inc(32'(oob_drops), CNT_BITS));
`ifdef EVT_MONOTONIC_CHECK_EN
                end else if (state == WIN_ACTIVE && delta[INPUT_BIT_TIME-1]) begin
                    ooo_drops <= CNT_BITS'(sat_inc(32'(ooo_drops), CNT_BITS));
`endif
                end else begin
                    s1_valid   <= 1'b1;
                    s1_evt.x   <= EVT_X_W'(x_scaled);
                    s1_evt.y   <= EVT_Y_W'(y_scaled);
                    s1_evt.pol <= polarity;
                    if (new_window) begin
                        state        <= WIN_ACTIVE;
                        window_start <= timestamp;
                        s1_evt.sow   <= 1'b1;
                        s1_evt.t     <= '0;
                    end else begin
                        s1_evt.sow   <= 1'b0;
                        s1_evt.t     <= EVT_T_W'(delta);
                    end
                end
            end
        end
    end

`ifndef EVT_MONOTONIC_CHECK_EN
    assign ooo_drops = '0;
`endif

    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign fifo_wr  = s1_valid && (!fifo_full || (out_valid && out_ready));
    assign fifo_din = {s1_evt.pol, s1_evt.sow | pending_sow,
                       s1_evt.t[INPUT_BIT_TIME-1:0],
                       s1_evt.y[INPUT_BIT_Y-1:0],
                       s1_evt.x[INPUT_BIT_X-1:0]};
    assign unused_evt_bits = ^s1_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_sow <= 1'b0;
            ovf_drops   <= '0;
        end else if (s1_valid) begin
            if (fifo_wr) begin
                pending_sow <= 1'b0;
            end else begin
                ovf_drops <= CNT_BITS'(sat_inc(32'(ovf_drops), CNT_BITS));
                if (s1_evt.sow) begin
                    pending_sow <= 1'b1;
                end
            end
        end
    end

    event_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (out_ready),
        .rd_data (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign {out_pol, out_sow, out_t, out_y, out_x} = fifo_dout;

endmodule

// File: tb/tb_event_input_frontend.sv
// Directed bench for event_input_frontend (WINDOW_LEN=100, FIFO_DEPTH=4).
module tb_event_input_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] timestamp;
    logic [7:0]  x_coord, y_coord;
    logic        polarity, is_valid, out_ready;

    logic [7:0]  out_x, out_y;
    logic [31:0] out_t;
    logic        out_pol, out_sow, out_valid;
    logic [2:0]  fifo_level;
    logic [15:0] oob_drops, ovf_drops, ooo_drops;

    logic [7:0]  s_out_x, s_out_y;
    logic [31:0] s_out_t;
    logic        s_out_pol, s_out_sow, s_out_valid;
    logic [2:0]  s_fifo_level;
    logic [1:0]  s_oob, s_ovf, s_ooo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    event_input_frontend #(
        .WINDOW_LEN (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk), .reset (reset), .timestamp (timestamp), .x_coord (x_coord),
        .y_coord (y_coord), .polarity (polarity), .is_valid (is_valid),
        .out_x (out_x), .out_y (out_y), .out_t (out_t), .out_pol (out_pol),
        .out_sow (out_sow), .out_valid (out_valid), .out_ready (out_ready),
        .fifo_level (fifo_level), .oob_drops (oob_drops), .ovf_drops (ovf_drops),
        .ooo_drops (ooo_drops)
    );

    event_input_frontend #(
        .WINDOW_LEN  (100),
        .FIFO_DEPTH  (4),
        .SCALE_SHIFT (1),
        .CNT_BITS    (2)
    ) dut_s (
        .clk (clk), .reset (reset), .timestamp (timestamp), .x_coord (x_coord),
        .y_coord (y_coord), .polarity (polarity), .is_valid (is_valid),
        .out_x (s_out_x), .out_y (s_out_y), .out_t (s_out_t), .out_pol (s_out_pol),
        .out_sow (s_out_sow), .out_valid (s_out_valid), .out_ready (out_ready),
        .fifo_level (s_fifo_level), .oob_drops (s_oob), .ovf_drops (s_ovf),
        .ooo_drops (s_ooo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ts, input logic [7:0] x, input logic [7:0] y, input logic p);
        timestamp = ts; x_coord = x; y_coord = y; polarity = p; is_valid = 1'b1;
        tick();
        is_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; is_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        n_vec++;
        if ({out_valid, fifo_level, oob_drops, ovf_drops, ooo_drops, out_x, out_y, out_t, out_pol, out_sow} !== '0) begin
            n_err++;
            $display("FAIL reset_main: got valid=%0b lvl=%0d oob=%0d ovf=%0d ooo=%0d t=%0d want all 0",
                     out_valid, fifo_level, oob_drops, ovf_drops, ooo_drops, out_t);
        end
        n_vec++;
        if ({s_out_valid, s_fifo_level, s_oob, s_ovf, s_ooo, s_out_x, s_out_y, s_out_t, s_out_pol, s_out_sow} !== '0) begin
            n_err++;
            $display("FAIL reset_scaled: got valid=%0b lvl=%0d oob=%0d want all 0", s_out_valid, s_fifo_level, s_oob);
        end
    endtask

    task automatic test_window();
        logic [31:0] ts_v [3];
        logic [31:0] t_v [3];
        logic        sow_v [3];
        ts_v = '{32'd1000, 32'd1050, 32'd1100};
        t_v  = '{32'd0, 32'd50, 32'd0};
        sow_v = '{1'b1, 1'b0, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ts_v[i], 8'd5, 8'd7, 1'b1);
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL window_latency[%0d]: out_valid got %0b want 0", i, out_valid);
            end
            tick();
            n_vec++;
            if ({out_valid, out_t, out_sow, out_x, out_y, out_pol} !== {1'b1, t_v[i], sow_v[i], 8'd5, 8'd7, 1'b1}) begin
                n_err++;
                $display("FAIL window[%0d]: got v=%0b t=%0d sow=%0b x=%0d y=%0d p=%0b want v=1 t=%0d sow=%0b x=5 y=7 p=1",
                         i, out_valid, out_t, out_sow, out_x, out_y, out_pol, t_v[i], sow_v[i]);
            end
        end
    endtask

    task automatic test_bounds();
        do_reset();
        out_ready = 1'b1;
        send(32'd10, 8'd128, 8'd0, 1'b0);
        tick(); tick(); tick();
        n_vec++;
        if ({out_valid, oob_drops, s_oob} !== {1'b0, 16'd1, 2'd1}) begin
            n_err++;
            $display("FAIL oob_x: got v=%0b oob=%0d s_oob=%0d want v=0 oob=1 s_oob=1", out_valid, oob_drops, s_oob);
        end
        send(32'd11, 8'd0, 8'd128, 1'b0);
        send(32'd12, 8'd200, 8'd3, 1'b0);
        send(32'd13, 8'd255, 8'd255, 1'b0);
        tick(); tick();
        n_vec++;
        if ({out_valid, s_out_valid, oob_drops, s_oob} !== {1'b0, 1'b0, 16'd4, 2'd3}) begin
            n_err++;
            $display("FAIL oob_sat: got v=%0b sv=%0b oob=%0d s_oob=%0d want v=0 sv=0 oob=4 s_oob=3",
                     out_valid, s_out_valid, oob_drops, s_oob);
        end
        send(32'd14, 8'd127, 8'd64, 1'b1);
        tick(); tick();
        n_vec++;
        if ({out_valid, out_x, out_y, out_t, out_sow} !== {1'b1, 8'd127, 8'd64, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL edge_accept: got v=%0b x=%0d y=%0d t=%0d sow=%0b want v=1 x=127 y=64 t=0 sow=1",
                     out_valid, out_x, out_y, out_t, out_sow);
        end
        n_vec++;
        if ({s_out_valid, s_out_x, s_out_y} !== {1'b1, 8'd63, 8'd32}) begin
            n_err++;
            $display("FAIL scaled: got v=%0b x=%0d y=%0d want v=1 x=63 y=32", s_out_valid, s_out_x, s_out_y);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(32'(i), 8'(i), 8'd0, 1'b0);
        end
        tick(); tick();
        n_vec++;
        if ({fifo_level, ovf_drops} !== {3'd4, 16'd2}) begin
            n_err++;
            $display("FAIL bp_full: got lvl=%0d ovf=%0d want lvl=4 ovf=2", fifo_level, ovf_drops);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({out_valid, out_x, out_t, out_sow} !== {1'b1, 8'd0, 32'd0, 1'b1}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%0b x=%0d t=%0d sow=%0b want v=1 x=0 t=0 sow=1",
                         k, out_valid, out_x, out_t, out_sow);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({out_valid, out_x, out_t, out_sow} !== {1'b1, 8'(i), 32'(i), (i == 0)}) begin
                n_err++;
                $display("FAIL bp_drain[%0d]: got v=%0b x=%0d t=%0d sow=%0b want v=1 x=%0d t=%0d",
                         i, out_valid, out_x, out_t, out_sow, i, i);
            end
            tick();
        end
        n_vec++;
        if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL bp_empty: got v=%0b lvl=%0d want v=0 lvl=0", out_valid, fifo_level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_pending_sow();
        logic [31:0] t_v [4];
        logic [7:0]  x_v [4];
        t_v = '{32'd1, 32'd2, 32'd3, 32'd10};
        x_v = '{8'd1, 8'd1, 8'd1, 8'd3};
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'd100 + 32'(i), 8'd1, 8'd1, 1'b0);
        end
        tick(); tick();
        send(32'd200, 8'd2, 8'd2, 1'b1);
        tick();
        n_vec++;
        if ({fifo_level, ovf_drops} !== {3'd4, 16'd1}) begin
            n_err++;
            $display("FAIL psow_drop: got lvl=%0d ovf=%0d want lvl=4 ovf=1", fifo_level, ovf_drops);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(32'd210, 8'd3, 8'd3, 1'b0);
        tick(); tick();
        n_vec++;
        if (fifo_level !== 3'd4) begin
            n_err++;
            $display("FAIL psow_refill: got lvl=%0d want 4", fifo_level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({out_valid, out_t, out_x, out_sow} !== {1'b1, t_v[i], x_v[i], (i == 3)}) begin
                n_err++;
                $display("FAIL psow_drain[%0d]: got v=%0b t=%0d x=%0d sow=%0b want v=1 t=%0d x=%0d",
                         i, out_valid, out_t, out_x, out_sow, t_v[i], x_v[i]);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] ts_v [3];
        logic [31:0] t_v [3];
        logic        sow_v [3];
        ts_v  = '{32'hFFFF_FFF0, 32'h10, 32'h60};
        t_v   = '{32'd0, 32'd32, 32'd0};
        sow_v = '{1'b1, 1'b0, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ts_v[i], 8'd9, 8'd9, 1'b0);
            tick(); tick();
            n_vec++;
            if ({out_valid, out_t, out_sow} !== {1'b1, t_v[i], sow_v[i]}) begin
                n_err++;
                $display("FAIL wrap[%0d]: got v=%0b t=%0d sow=%0b want v=1 t=%0d sow=%0b",
                         i, out_valid, out_t, out_sow, t_v[i], sow_v[i]);
            end
        end
    endtask

    task automatic test_ooo_and_reset();
        do_reset();
        out_ready = 1'b1;
        send(32'd500, 8'd1, 8'd1, 1'b0);
        tick(); tick();
        n_vec++;
        if ({out_valid, out_t, out_sow} !== {1'b1, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL ooo_first: got v=%0b t=%0d sow=%0b want v=1 t=0 sow=1", out_valid, out_t, out_sow);
        end
        send(32'd400, 8'd2, 8'd2, 1'b0);
        tick(); tick();
`ifdef EVT_MONOTONIC_CHECK_EN
        n_vec++;
        if ({out_valid, ooo_drops} !== {1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL ooo_drop: got v=%0b ooo=%0d want v=0 ooo=1", out_valid, ooo_drops);
        end
`else
        n_vec++;
        if ({out_valid, out_t, out_sow, out_x, ooo_drops} !== {1'b1, 32'd0, 1'b1, 8'd2, 16'd0}) begin
            n_err++;
            $display("FAIL ooo_newwin: got v=%0b t=%0d sow=%0b x=%0d ooo=%0d want v=1 t=0 sow=1 x=2 ooo=0",
                     out_valid, out_t, out_sow, out_x, ooo_drops);
        end
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'd600 + 32'(i), 8'd4, 8'd4, 1'b0);
        end
        tick(); tick();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: out_valid got %0b want 1", out_valid);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, fifo_level, ovf_drops, oob_drops, ooo_drops, out_t, out_x, out_sow} !== '0) begin
            n_err++;
            $display("FAIL midrst: got v=%0b lvl=%0d ovf=%0d t=%0d want all 0", out_valid, fifo_level, ovf_drops, out_t);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        timestamp = '0; x_coord = '0; y_coord = '0;
        polarity = 1'b0; is_valid = 1'b0; out_ready = 1'b0;
        #2;
        test_reset();
        test_window();
        test_bounds();
        test_backpressure();
        test_pending_sow();
        test_wrap();
        test_ooo_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
